// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the elevator call scheduler: floor codes, direction
//   codes, the scheduler state enum and the SCAN target-selection helpers.
//   No ports; imported by call_scheduler.
package elevator_pkg;

   // Floor codes as reported by the floor controller.
   localparam logic [1:0] FloorF1 = 2'd1;
   localparam logic [1:0] FloorF2 = 2'd2;
   localparam logic [1:0] FloorF3 = 2'd3;

   // Direction codes (controller dir input and scheduler sweep).
   localparam logic [1:0] DirUp   = 2'd1;
   localparam logic [1:0] DirDown = 2'd2;
   localparam logic [1:0] DirHold = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitAck,
      StTravel,
      StDwell
   } sched_state_e;

   typedef struct packed {
      logic [1:0] floor;
      logic [1:0] sweep;
   } scan_sel_t;

   // One-hot floor vector, bit f-1 for floor f. Anything outside F2/F3 maps to F1.
   function automatic logic [2:0] floor_onehot(input logic [1:0] f);
      logic [2:0] oh;
      case (f)
         FloorF2: oh = 3'b010;
         FloorF3: oh = 3'b100;
         default: oh = 3'b001;
      endcase
      return oh;
   endfunction

   // SCAN selection: serve the current floor if requested, else the nearest
   // request ahead in the sweep, else the nearest behind with the sweep reversed.
   // cur must already be in 1..3; req must be nonzero for the result to matter.
   function automatic scan_sel_t scan_select(input logic [2:0] req,
                                             input logic [1:0] cur,
                                             input logic [1:0] sweep);
      scan_sel_t  sel;
      logic       hit;
      logic       found_up;
      logic       found_dn;
      logic [1:0] up_f;
      logic [1:0] dn_f;
      hit      = 1'b0;
      found_up = 1'b0;
      found_dn = 1'b0;
      up_f     = cur;
      dn_f     = cur;
      case (cur)
         FloorF2: begin
            hit      = req[1];
            found_up = req[2];
            up_f     = FloorF3;
            found_dn = req[0];
            dn_f     = FloorF1;
         end
         FloorF3: begin
            hit      = req[2];
            found_dn = req[1] | req[0];
            dn_f     = req[1] ? FloorF2 : FloorF1;
         end
         default: begin
            hit      = req[0];
            found_up = req[1] | req[2];
            up_f     = req[1] ? FloorF2 : FloorF3;
         end
      endcase
      sel.floor = cur;
      sel.sweep = sweep;
      if (!hit) begin
         if (sweep == DirDown) begin
            if (found_dn) begin
               sel.floor = dn_f;
            end else begin
               sel.floor = up_f;
               sel.sweep = DirUp;
            end
         end else begin
            if (found_up) begin
               sel.floor = up_f;
            end else begin
               sel.floor = dn_f;
               sel.sweep = DirDown;
            end
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
//   Counts the door-open dwell. start is held high for the whole dwell; done
//   pulses on the last of DWELL_CYCLES cycles. The count clears whenever start
//   is low, so each dwell begins from zero.
//   Ports: clk, rst (sync, active-high), start (dwell in progress), done.
module dwell_timer #(
   parameter int unsigned DWELL_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic done
);

   localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DWELL_CYCLES - 1);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   always_comb begin
      done  = start && (cnt_q == LastCnt);
      cnt_d = '0;
      if (start && !done) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/call_scheduler.sv
// call_scheduler
//   Latches car/hall call buttons, picks a target floor with a SCAN policy,
//   issues a one-cycle request to the floor controller, follows it to the
//   target and holds the door open for the dwell period.
//   Ports: clk, rst (sync, active-high), btn[5:0] (car F1-F3, hall F1-F3),
//          floor[1:0], dir[1:0] (monitored only), busy,
//          req_out[5:0] (one-hot floor request), door_open, pending[5:0],
//          target[1:0].
module call_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 100_000_000,
   parameter int unsigned ACK_TIMEOUT  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] btn,
   input  logic [1:0] floor,
   input  logic [1:0] dir,
   input  logic       busy,
   output logic [5:0] req_out,
   output logic       door_open,
   output logic [5:0] pending,
   output logic [1:0] target
);

   localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [AckW-1:0] LastAck = AckW'(ACK_TIMEOUT - 1);

   sched_state_e    state_q, state_d;
   logic [5:0]      pending_q, pending_d;
   logic [1:0]      target_q, target_d;
   logic [1:0]      sweep_q, sweep_d;
   logic [AckW-1:0] ack_cnt_q, ack_cnt_d;

   logic [1:0]  cur_floor;
   logic [2:0]  floor_req;
   logic [2:0]  target_oh;
   scan_sel_t   sel;
   logic        select_now;
   logic        dwelling;
   logic        dwell_done;
   logic        unused_dir;

   // Direction is informational only.
   assign unused_dir = (dir == DirHold);

   // A floor code of 0 is treated as F1.
   assign cur_floor  = (floor == 2'd0) ? FloorF1 : floor;
   assign floor_req  = pending_q[2:0] | pending_q[5:3];
   assign target_oh  = floor_onehot(target_q);
   assign sel        = scan_select(floor_req, cur_floor, sweep_q);
   assign select_now = (state_q == StIdle) && (|floor_req) && !busy;

   dwell_timer #(
      .DWELL_CYCLES (DWELL_CYCLES)
   ) u_dwell_timer (
      .clk   (clk),
      .rst   (rst),
      .start (dwelling),
      .done  (dwell_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (select_now) begin
               state_d = (sel.floor == cur_floor) ? StDwell : StIssue;
            end
         end
         StIssue:   state_d = StWaitAck;
         StWaitAck: begin
            if (busy) begin
               state_d = StTravel;
            end else if (ack_cnt_q == LastAck) begin
               state_d = StIdle;
            end
         end
         StTravel: begin
            if (!busy && (cur_floor == target_q)) begin
               state_d = StDwell;
            end
         end
         StDwell: begin
            if (dwell_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      dwelling  = (state_q == StDwell);
      door_open = dwelling;
      req_out   = (state_q == StIssue) ? {3'b000, target_oh} : 6'b000000;
   end

   // Datapath next-state: call latch, target/sweep, ack timeout.
   always_comb begin
      target_d = target_q;
      sweep_d  = sweep_q;
      if (select_now) begin
         target_d = sel.floor;
         sweep_d  = sel.sweep;
      end

      ack_cnt_d = '0;
      if ((state_q == StWaitAck) && !busy) begin
         ack_cnt_d = ack_cnt_q + 1'b1;
      end

      // Clearing after the OR means a press at the dwell floor is absorbed.
      pending_d = pending_q | btn;
      if (dwelling) begin
         pending_d = pending_d & ~{target_oh, target_oh};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         target_q  <= FloorF1;
         sweep_q   <= DirUp;
         ack_cnt_q <= '0;
      end else begin
         pending_q <= pending_d;
         target_q  <= target_d;
         sweep_q   <= sweep_d;
         ack_cnt_q <= ack_cnt_d;
      end
   end

   assign pending = pending_q;
   assign target  = target_q;

endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler
//   Directed self-checking bench for call_scheduler with DWELL_CYCLES=10 and
//   ACK_TIMEOUT=8. Inputs change 1 ns after a rising edge; outputs are sampled
//   at the same point.
module tb_call_scheduler;

   logic       clk;
   logic       rst;
   logic [5:0] btn;
   logic [1:0] floor;
   logic [1:0] dir;
   logic       busy;
   logic [5:0] req_out;
   logic       door_open;
   logic [5:0] pending;
   logic [1:0] target;

   int total = 0;
   int bad   = 0;
   int n;
   int k;

   call_scheduler #(
      .DWELL_CYCLES (10),
      .ACK_TIMEOUT  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .floor     (floor),
      .dir       (dir),
      .busy      (busy),
      .req_out   (req_out),
      .door_open (door_open),
      .pending   (pending),
      .target    (target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   // Counts door_open-high samples until the door closes (bounded).
   task automatic wait_dwell(input string tag, output int cycles);
      cycles = 0;
      while (door_open === 1'b1 && cycles < 40) begin
         cycles++;
         tick();
      end
      check(tag, {31'd0, door_open}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      btn   = 6'b000000;
      floor = 2'd1;
      dir   = 2'd3;
      busy  = 1'b0;
      tick();
      tick();
      check("rst_req_out", req_out, 6'b000000);
      check("rst_door", door_open, 0);
      check("rst_pending", pending, 6'b000000);
      check("rst_target", target, 1);
      rst = 1'b0;

      // F1 -> car call F3: latch, select, issue, travel, dwell.
      btn = 6'b000100;
      tick();
      btn = 6'b000000;
      check("b_latch", pending, 6'b000100);
      check("b_no_req_yet", req_out, 6'b000000);
      tick();
      check("b_req", req_out, 6'b000100);
      check("b_target", target, 3);
      busy = 1'b1;
      tick();
      check("b_req_one_cycle", req_out, 6'b000000);
      tick();
      floor = 2'd2;
      tick();
      check("b_no_door_mid", door_open, 0);
      floor = 2'd3;
      busy  = 1'b0;
      tick();
      check("b_door", door_open, 1);
      wait_dwell("b_dwell_end", n);
      check("b_dwell_len", n, 10);
      check("b_pending_clr", pending, 6'b000000);

      // Hall call at the current floor: straight to dwell, no request.
      floor = 2'd1;
      dir   = 2'd1;
      btn   = 6'b001000;
      tick();
      btn = 6'b000000;
      check("c_latch", pending, 6'b001000);
      tick();
      check("c_door", door_open, 1);
      check("c_no_req", req_out, 6'b000000);
      check("c_target", target, 1);
      tick();
      check("c_pend_clr", pending, 6'b000000);
      wait_dwell("c_dwell_end", n);

      // Dwell at F2: F2 presses absorbed, F1 press latched.
      floor = 2'd2;
      dir   = 2'd2;
      btn   = 6'b010010;
      tick();
      btn = 6'b000000;
      check("d_latch", pending, 6'b010010);
      tick();
      check("d_door", door_open, 1);
      check("d_target", target, 2);
      btn = 6'b010010;
      tick();
      btn = 6'b000001;
      tick();
      btn = 6'b000000;
      check("d_absorb", pending, 6'b000001);
      wait_dwell("d_dwell_end", n);
      check("d_pend_end", pending, 6'b000001);
      tick();
      check("d_target_f1", target, 1);
      check("d_req_f1", req_out, 6'b000001);
      busy = 1'b1;
      tick();
      tick();
      btn = 6'b100000;
      tick();
      btn = 6'b000000;
      check("d_pend_travel", pending, 6'b100001);
      // Reset mid-travel with a button pressed in the same cycle.
      rst = 1'b1;
      btn = 6'b000010;
      tick();
      rst  = 1'b0;
      btn  = 6'b000000;
      busy = 1'b0;
      check("d_rst_req", req_out, 6'b000000);
      check("d_rst_door", door_open, 0);
      check("d_rst_pending", pending, 6'b000000);
      check("d_rst_target", target, 1);
      tick();
      check("d_rst_quiet", req_out, 6'b000000);

      // Sweep up after reset: from F2 with F1 and F3 requested, F3 first.
      floor = 2'd2;
      btn   = 6'b000101;
      tick();
      btn = 6'b000000;
      tick();
      check("e_target_up", target, 3);
      check("e_req_f3", req_out, 6'b000100);
      busy = 1'b1;
      tick();
      tick();
      floor = 2'd3;
      busy  = 1'b0;
      tick();
      check("e_door_f3", door_open, 1);
      wait_dwell("e_dwell_end", n);
      check("e_pend_left", pending, 6'b000001);
      tick();
      check("e_target_down", target, 1);
      check("e_req_f1", req_out, 6'b000001);
      // Controller never acknowledges: re-issue after the timeout.
      k = 0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (req_out !== 6'b000000) k++;
      end
      check("e_no_early_repulse", k, 0);
      tick();
      check("e_repulse", req_out, 6'b000001);
      check("e_pend_kept", pending, 6'b000001);
      check("e_target_kept", target, 1);
      busy = 1'b1;
      tick();
      tick();
      floor = 2'd2;
      tick();
      floor = 2'd1;
      busy  = 1'b0;
      tick();
      check("e_door_f1", door_open, 1);
      wait_dwell("e_f1_end", n);
      check("e_pend_f1", pending, 6'b000000);

      // Sweep now down: from F2 with F1 and F3 requested, F1 first.
      floor = 2'd2;
      btn   = 6'b100001;
      tick();
      btn = 6'b000000;
      tick();
      check("f_target_down", target, 1);
      check("f_req_f1", req_out, 6'b000001);
      busy = 1'b1;
      tick();
      tick();
      floor = 2'd1;
      busy  = 1'b0;
      tick();
      check("f_door", door_open, 1);
      tick();
      tick();
      check("f_pend_mid", pending, 6'b100000);
      // Reset mid-dwell.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("f_rst_door", door_open, 0);
      check("f_rst_pending", pending, 6'b000000);
      check("f_rst_target", target, 1);

      // Floor code 0 behaves as F1.
      floor = 2'd0;
      btn   = 6'b000001;
      tick();
      btn = 6'b000000;
      tick();
      check("g_floor0_door", door_open, 1);
      check("g_floor0_no_req", req_out, 6'b000000);
      wait_dwell("g_dwell_end", n);
      check("g_dwell_len", n, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 100_000_000, door-open dwell length in clk cycles (1 s at 100 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 8, maximum cycles to wait for controller busy after a request pulse.
REQ-003 clk  input  1  single system clock (100 MHz); all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn  input  6  level call buttons; bits 0-2 car calls F1-F3, bits 3-5 hall calls F1-F3.
REQ-006 floor  input  2  current floor from the floor controller (1=F1, 2=F2, 3=F3).
REQ-007 dir  input  2  controller direction (1=up, 2=down, 3=hold); monitored only.
REQ-008 busy  input  1  controller busy flag; high while travelling to a destination.
REQ-009 req_out  output  6  one-hot request to the floor controller; bit f-1 targets floor f; bits 3-5 never driven.
REQ-010 door_open  output  1  high during dwell at a served floor.
REQ-011 pending  output  6  latched outstanding calls, same bit map as btn.
REQ-012 target  output  2  floor currently being served or last served.

Function
REQ-013 pending SHALL set bit i on any cycle btn[i]=1 (level OR) and clear only per REQ-022 or reset.
REQ-014 Floor request vector r[f] SHALL equal pending[f-1] OR pending[f+2], for f=1..3.
REQ-015 States SHALL be IDLE, ISSUE, WAIT_ACK, TRAVEL, DWELL.
REQ-016 IDLE: if r is nonzero and busy=0, SHALL compute target per REQ-017; go DWELL if target=floor, otherwise ISSUE.
REQ-017 Target selection (SCAN): if r[floor] is set, pick floor; else pick the nearest requested floor in sweep direction; else pick the nearest in the opposite direction and invert sweep; sweep SHALL reset to up.
REQ-018 ISSUE: req_out SHALL be one-hot for target for exactly one cycle, zero in every other state; next state WAIT_ACK.
REQ-019 WAIT_ACK: on busy=1 go TRAVEL; if busy stays 0 for ACK_TIMEOUT cycles, go IDLE and re-select without clearing pending.
REQ-020 TRAVEL: when busy=0 and floor=target, go DWELL; intermediate floors passed are not served.
REQ-021 DWELL: door_open=1 for exactly DWELL_CYCLES cycles, then IDLE.
REQ-022 In every DWELL cycle, pending bits target-1 and target+2 SHALL be cleared; a button for the dwell floor pressed in that cycle is absorbed (clear wins), while presses at other floors latch normally.
REQ-023 target and sweep SHALL change only on the IDLE selection cycle.
REQ-024 Latency: from btn assertion at floor f≠floor with scheduler idle, req_out SHALL pulse on the 3rd rising edge (latch, select, issue).
REQ-025 dir SHALL NOT affect decisions; floor values 0 SHALL be treated as F1.

Reset
REQ-026 On rst=1 at a clock edge: state IDLE, pending 0, req_out 0, door_open 0, target 1, sweep up, dwell and timeout counters 0.
REQ-027 Reset mid-TRAVEL or mid-DWELL SHALL abandon the operation, and btn sampled in the same cycle SHALL be ignored.

Structure
REQ-028 Shared package elevator_pkg SHALL hold floor codes F1-F3, direction codes up/down/hold, and the scheduler state enum.
REQ-029 Dwell counter SHALL be sub-module dwell_timer (start, done, DWELL_CYCLES parameter); the ACK timeout counter stays inline.
REQ-030 Target: 120-400 lines RTL; counters sized by parameter (32-bit dwell max).

Verification (DWELL_CYCLES=10, ACK_TIMEOUT=8 in bench)
REQ-031 Reset, floor=1, btn=6'b000100 for 1 cycle -> req_out=6'b000100 one cycle, target=3; busy model travels; floor=3 -> door_open 10 cycles, pending=0.
REQ-032 floor=2, sweep up, r={F1,F3} pending -> target=3 first, then target=1, sweep=down.
REQ-033 floor=1, btn=6'b001000 -> no req_out pulse, immediate DWELL, door_open=1, pending[3] cleared.
REQ-034 busy never asserts after ISSUE -> return to IDLE after 8 cycles, req_out re-pulses, pending unchanged.
REQ-035 During DWELL at F2, btn=6'b010010 and btn=6'b000001 -> F2 bits absorbed, pending=6'b000001 at dwell end.
REQ-036 rst asserted mid-TRAVEL with pending=6'b100001 -> next cycle all outputs at reset values, pending=0.
